apb_master_async_cdc: RTL

Parametrised APB4 master-side bridge for crossing into an asynchronous clock domain over a four-phase req/ack handshake. It sits between a local APB bus and the asynchronous slave-side port. Compared with the previous generation, it adds:
- registered, stable payload and response;
- configurable synchronizer depth;
- PSTRB/PPROT forwarding;
- local rejection of illegal reads;
- an optional timeout that completes the APB transfer with an error while keeping the handshake intact.

---
 rtl/apb_master_async_cdc_if.sv | 55 +++++
 rtl/apb_master_async_cdc.sv | 126 ++++++++++++
 2 files changed

// File: rtl/apb_master_async_cdc_if.sv
// Bundles the local APB port and the asynchronous far-side port of apb_master_async_cdc.
// The master modport is the bridge's view and the slave modport is the surrounding environment's view.
interface apb_master_async_cdc_if #(
    parameter int APB_DATA_WIDTH = 32,
    parameter int APB_ADDR_WIDTH = 32
);
    localparam int STRB_W = APB_DATA_WIDTH / 8;

    logic [APB_ADDR_WIDTH-1:0] PADDR_i;
    logic [APB_DATA_WIDTH-1:0] PWDATA_i;
    logic                      PWRITE_i;
    logic [STRB_W-1:0]         PSTRB_i;
    logic [2:0]                PPROT_i;
    logic                      PSEL_i;
    logic                      PENABLE_i;
    logic [APB_DATA_WIDTH-1:0] PRDATA_o;
    logic                      PREADY_o;
    logic                      PSLVERR_o;
    logic                      asynch_req_o;
    logic                      asynch_ack_i;
    logic [APB_ADDR_WIDTH-1:0] async_PADDR_o;
    logic [APB_DATA_WIDTH-1:0] async_PWDATA_o;
    logic                      async_PWRITE_o;
    logic [STRB_W-1:0]         async_PSTRB_o;
    logic [2:0]                async_PPROT_o;
    logic                      async_PSEL_o;
    logic [APB_DATA_WIDTH-1:0] async_PRDATA_i;
    logic                      async_PSLVERR_i;
    logic                      timeout_o;
    logic                      timeout_clr_i;

    modport master (
        input  PADDR_i, PWDATA_i, PWRITE_i, PSTRB_i, PPROT_i, PSEL_i, PENABLE_i,
        output PRDATA_o, PREADY_o, PSLVERR_o,
        output asynch_req_o,
        input  asynch_ack_i,
        output async_PADDR_o, async_PWDATA_o, async_PWRITE_o, async_PSTRB_o, async_PPROT_o,
        output async_PSEL_o,
        input  async_PRDATA_i, async_PSLVERR_i,
        output timeout_o,
        input  timeout_clr_i
    );

    modport slave (
        output PADDR_i, PWDATA_i, PWRITE_i, PSTRB_i, PPROT_i, PSEL_i, PENABLE_i,
        input  PRDATA_o, PREADY_o, PSLVERR_o,
        input  asynch_req_o,
        output asynch_ack_i,
        input  async_PADDR_o, async_PWDATA_o, async_PWRITE_o, async_PSTRB_o, async_PPROT_o,
        input  async_PSEL_o,
        output async_PRDATA_i, async_PSLVERR_i,
        input  timeout_o,
        output timeout_clr_i
    );
endinterface

// File: rtl/apb_master_async_cdc.sv
// APB master-side bridge into an asynchronous domain over a four-phase req/ack handshake,
// with a synchronized ack, registered payload/response, illegal-read rejection and optional timeout.
module apb_master_async_cdc #(
    parameter int APB_DATA_WIDTH = 32,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    apb_master_async_cdc_if.master bus
);
    localparam int STRB_W = APB_DATA_WIDTH / 8;
    localparam int CNT_W  = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {IDLE, LERR, REQ, ABANDON, REQ_DOWN} state_t;

    state_t                    state;
    logic [SYNC_STAGES-1:0]    ack_sync_p;
    logic                      ack_sync;
    logic [CNT_W-1:0]          cnt;
    logic                      req;
    logic                      pready;
    logic                      pslverr;
    logic [APB_DATA_WIDTH-1:0] prdata;
    logic [APB_ADDR_WIDTH-1:0] paddr_q;
    logic [APB_DATA_WIDTH-1:0] pwdata_q;
    logic                      pwrite_q;
    logic [STRB_W-1:0]         pstrb_q;
    logic [2:0]                pprot_q;
    logic                      timeout_q;
    logic                      access;

    // Ack synchronizer: the FSM only ever looks at the last stage.
    always_ff @(posedge clk) begin
        if (rst) ack_sync_p <= '0;
        else     ack_sync_p <= {ack_sync_p[SYNC_STAGES-2:0], bus.asynch_ack_i};
    end

    assign ack_sync = ack_sync_p[SYNC_STAGES-1];
    // A stale ack from the previous handshake blocks acceptance until it has dropped.
    assign access   = bus.PSEL_i & bus.PENABLE_i & ~ack_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req       <= 1'b0;
            pready    <= 1'b0;
            pslverr   <= 1'b0;
            prdata    <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            pstrb_q   <= '0;
            pprot_q   <= '0;
            cnt       <= '0;
            timeout_q <= 1'b0;
        end else begin
            pready  <= 1'b0;
            pslverr <= 1'b0;
            // Assigned before the FSM so a timeout in the same cycle overrides the clear.
            if (bus.timeout_clr_i) timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (access) begin
                        if (!bus.PWRITE_i && (bus.PSTRB_i != '0)) begin
                            pready  <= 1'b1;
                            pslverr <= 1'b1;
                            prdata  <= '0;
                            state   <= LERR;
                        end else begin
                            paddr_q  <= bus.PADDR_i;
                            pwdata_q <= bus.PWDATA_i;
                            pwrite_q <= bus.PWRITE_i;
                            pstrb_q  <= bus.PSTRB_i;
                            pprot_q  <= bus.PPROT_i;
                            cnt      <= '0;
                            req      <= 1'b1;
                            state    <= REQ;
                        end
                    end
                end
                LERR: state <= IDLE;
                REQ: begin
                    if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                    if (ack_sync) begin
                        prdata  <= bus.async_PRDATA_i;
                        pslverr <= bus.async_PSLVERR_i;
                        pready  <= 1'b1;
                        req     <= 1'b0;
                        state   <= REQ_DOWN;
                    end else if ((TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST)) begin
                        pready    <= 1'b1;
                        pslverr   <= 1'b1;
                        prdata    <= '0;
                        timeout_q <= 1'b1;
                        state     <= ABANDON;
                    end
                end
                // Keep req up until the far side answers so the handshake stays four-phase.
                ABANDON: begin
                    if (ack_sync) begin
                        req   <= 1'b0;
                        state <= REQ_DOWN;
                    end
                end
                REQ_DOWN: if (!ack_sync) state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    assign bus.PRDATA_o       = prdata;
    assign bus.PREADY_o       = pready;
    assign bus.PSLVERR_o      = pslverr;
    assign bus.asynch_req_o   = req;
    assign bus.async_PSEL_o   = req;
    assign bus.async_PADDR_o  = paddr_q;
    assign bus.async_PWDATA_o = pwdata_q;
    assign bus.async_PWRITE_o = pwrite_q;
    assign bus.async_PSTRB_o  = pstrb_q;
    assign bus.async_PPROT_o  = pprot_q;
    assign bus.timeout_o      = timeout_q;
endmodule
